// File: rtl/lsu_ctrl_if.sv
// Load/store unit bundle: pipeline request, data-memory beat port and completion response.
// The LSU uses the master view; the pipeline/memory environment uses the slave view.
interface lsu_ctrl_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_err;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit: one request at a time, byte enables, optional two-beat split of
// word-crossing accesses, sign/zero-extended load return.
module lsu_ctrl #(
    parameter int XLEN           = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.master bus
);
    localparam int W    = XLEN / 8;
    localparam int OFFW = $clog2(W);
    localparam int SW   = $clog2(2 * XLEN);
    localparam bit IS64 = (XLEN == 64);

    typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

    state_t            state_reg;
    logic              req_ready_reg;
    logic              mem_valid_reg;
    logic              mem_we_reg;
    logic [XLEN-1:0]   mem_addr_reg;
    logic [XLEN-1:0]   mem_wdata_reg;
    logic [W-1:0]      mem_be_reg;
    logic              rsp_valid_reg;
    logic [XLEN-1:0]   rsp_data_reg;
    logic              rsp_err_reg;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [OFFW-1:0]   off_reg;
    logic              split_reg;
    logic [W-1:0]      be_hi_reg;
    logic [XLEN-1:0]   wdata_hi_reg;
    logic [XLEN-1:0]   rdata0_reg;

    // Request decode, evaluated on the incoming request while in IDLE
    logic [OFFW-1:0]   req_off;
    logic [3:0]        req_size;
    logic [5:0]        req_end;
    logic              req_split;
    logic              req_legal;
    logic              req_err;
    logic [XLEN-1:0]   req_aligned;
    logic [2*XLEN-1:0] req_wd_full;
    wire  [2*W-1:0]    req_be_full;

    assign req_off     = bus.req_addr[OFFW-1:0];
    assign req_size    = 4'd1 << bus.req_funct3[1:0];
    assign req_end     = 6'(req_off) + 6'(req_size);
    assign req_split   = (req_end > 6'(W));
    assign req_err     = !req_legal || (req_split && !MISALIGN_SPLIT);
    assign req_aligned = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign req_wd_full = {bus.req_wdata, bus.req_wdata} << {req_off, 3'b000};

    always_comb begin
        req_legal = 1'b0;
        if (bus.req_we) begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010: req_legal = 1'b1;
                3'b011:                 req_legal = IS64;
                default:                req_legal = 1'b0;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                3'b011, 3'b110:                         req_legal = IS64;
                default:                                req_legal = 1'b0;
            endcase
        end
    end

    // Lane i of the two-word window is enabled when off <= i < off+S
    generate
        for (genvar gi = 0; gi < 2 * W; gi++) begin : g_be
            assign req_be_full[gi] = (6'(gi) >= 6'(req_off)) && (6'(gi) < req_end);
        end
    endgenerate

    // Load return: the beat completing this cycle supplies the newest word
    logic [XLEN-1:0]   ld_lo;
    logic [XLEN-1:0]   ld_hi;
    logic [2*XLEN-1:0] ld_shift;
    logic [6:0]        ld_bits;
    logic [SW-1:0]     ld_sign_idx;
    logic              ld_sign;
    wire  [XLEN-1:0]   ld_ext;

    always_comb begin
        ld_lo = rdata0_reg;
        ld_hi = '0;
        if (state_reg == BEAT0 || state_reg == WAIT0) ld_lo = bus.mem_rdata;
        if (state_reg == BEAT1 || state_reg == WAIT1) ld_hi = bus.mem_rdata;
    end

    assign ld_shift    = {ld_hi, ld_lo} >> {off_reg, 3'b000};
    assign ld_bits     = 7'd8 << funct3_reg[1:0];
    assign ld_sign_idx = SW'(ld_bits - 7'd1);
    assign ld_sign     = ld_shift[ld_sign_idx] & ~funct3_reg[2];

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
            assign ld_ext[gi] = (7'(gi) < ld_bits) ? ld_shift[gi] : ld_sign;
        end
    endgenerate

    // A beat completes on rvalid in WAIT, or on rvalid together with ready in BEAT
    logic beat_done;
    assign beat_done = ((state_reg == BEAT0 || state_reg == BEAT1) && bus.mem_ready && bus.mem_rvalid)
                    || ((state_reg == WAIT0 || state_reg == WAIT1) && bus.mem_rvalid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            mem_valid_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            we_reg        <= 1'b0;
            funct3_reg    <= '0;
            off_reg       <= '0;
            split_reg     <= 1'b0;
            be_hi_reg     <= '0;
            wdata_hi_reg  <= '0;
            rdata0_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_reg <= 1'b0;
                        we_reg        <= bus.req_we;
                        funct3_reg    <= bus.req_funct3;
                        off_reg       <= req_off;
                        split_reg     <= req_split;
                        be_hi_reg     <= req_be_full[2*W-1:W];
                        wdata_hi_reg  <= req_wd_full[2*XLEN-1:XLEN];
                        if (req_err) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_data_reg  <= '0;
                            state_reg     <= RESP;
                        end else begin
                            mem_valid_reg <= 1'b1;
                            mem_we_reg    <= bus.req_we;
                            mem_addr_reg  <= req_aligned;
                            mem_be_reg    <= req_be_full[W-1:0];
                            mem_wdata_reg <= req_wd_full[XLEN-1:0];
                            state_reg     <= BEAT0;
                        end
                    end
                end
                BEAT0, WAIT0: begin
                    if (beat_done) begin
                        rdata0_reg <= bus.mem_rdata;
                        if (split_reg) begin
                            mem_valid_reg <= 1'b1;
                            mem_addr_reg  <= mem_addr_reg + XLEN'(W);
                            mem_be_reg    <= be_hi_reg;
                            mem_wdata_reg <= wdata_hi_reg;
                            state_reg     <= BEAT1;
                        end else begin
                            mem_valid_reg <= 1'b0;
                            rsp_valid_reg <= 1'b1;
                            rsp_data_reg  <= we_reg ? '0 : ld_ext;
                            state_reg     <= RESP;
                        end
                    end else if (state_reg == BEAT0 && bus.mem_ready) begin
                        mem_valid_reg <= 1'b0;
                        state_reg     <= WAIT0;
                    end
                end
                BEAT1, WAIT1: begin
                    if (beat_done) begin
                        mem_valid_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= we_reg ? '0 : ld_ext;
                        state_reg     <= RESP;
                    end else if (state_reg == BEAT1 && bus.mem_ready) begin
                        mem_valid_reg <= 1'b0;
                        state_reg     <= WAIT1;
                    end
                end
                RESP: begin
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    rsp_data_reg  <= '0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.mem_valid = mem_valid_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_be    = mem_be_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl (XLEN=32): byte-array memory behind a randomly stalling bus, reference
// results computed per byte from the request, plus a second instance with splitting disabled.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.XLEN(32)) bus  ();
    lsu_ctrl_if #(.XLEN(32)) bus2 ();

    lsu_ctrl #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
    lsu_ctrl #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem_bytes [0:1023];
    bit          fast_bus   = 1'b0;
    bit          hold_ready = 1'b0;
    int          pend       = 0;
    logic [31:0] pend_data;
    bit          dut2_mem_seen = 1'b0;

    logic [31:0] cap_addr [$];
    logic [3:0]  cap_be   [$];
    logic        cap_we   [$];
    logic [31:0] cap_wd   [$];

    int          last_cycles;
    logic [31:0] last_data;
    logic        last_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] read_word(input logic [31:0] a);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = mem_bytes[{a[9:2], 2'(k)}];
        return v;
    endfunction

    task automatic poke_word(input logic [31:0] a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) mem_bytes[10'(a + 32'(k))] = v[8*k +: 8];
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    // Memory side: random ready, read data now or 1-2 cycles later, stray rvalids while idle
    initial begin
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (rst) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = pend_data;
                end
            end else if (bus.mem_valid && !hold_ready && (fast_bus || $urandom_range(0, 9) < 6)) begin
                logic [31:0] rd;
                bus.mem_ready = 1'b1;
                cap_addr.push_back(bus.mem_addr);
                cap_be.push_back(bus.mem_be);
                cap_we.push_back(bus.mem_we);
                cap_wd.push_back(bus.mem_wdata);
                if (bus.mem_we)
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be[b]) mem_bytes[{bus.mem_addr[9:2], 2'(b)}] = bus.mem_wdata[8*b +: 8];
                rd = read_word(bus.mem_addr);
                if (fast_bus || $urandom_range(0, 1) == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rd;
                end else begin
                    pend      = $urandom_range(1, 2);
                    pend_data = rd;
                end
            end else if (!bus.mem_valid && $urandom_range(0, 9) == 0) begin
                bus.mem_rvalid = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus2.mem_valid === 1'b1) dut2_mem_seen = 1'b1;
    end

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        int          s;
        int          a;
        bit          legal;
        logic [31:0] exp_data;
        logic [63:0] v;
        logic [31:0] eb_addr [$];
        logic [3:0]  eb_be   [$];
        logic [31:0] eb_wd   [$];
        int          cycles;
        int          n;

        s        = 1 << f3[1:0];
        a        = int'(addr);
        legal    = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_data = '0;
        if (legal) begin
            for (int w = a & ~3; w < a + s; w += 4) begin
                logic [3:0]  be;
                logic [31:0] wd;
                be = '0;
                wd = '0;
                for (int b = 0; b < 4; b++)
                    if (w + b >= a && w + b < a + s) begin
                        be[b]        = 1'b1;
                        wd[8*b +: 8] = wdata[8*(w + b - a) +: 8];
                    end
                eb_addr.push_back(32'(w));
                eb_be.push_back(be);
                eb_wd.push_back(wd);
            end
            if (!we) begin
                v = '0;
                for (int k = 0; k < s; k++) v[8*k +: 8] = mem_bytes[10'(a + k)];
                for (int i = 0; i < 32; i++)
                    exp_data[i] = (i < 8 * s) ? v[i] : (f3[2] ? 1'b0 : v[8*s-1]);
            end
        end

        cap_addr.delete(); cap_be.delete(); cap_we.delete(); cap_wd.delete();
        @(negedge clk);
        check({tag, ":req_ready_idle"}, bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        cycles = 1;
        while (bus.rsp_valid !== 1'b1 && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, ":rsp_valid"}, bus.rsp_valid, 1);
        check({tag, ":rsp_err"},   bus.rsp_err, !legal);
        check({tag, ":rsp_data"},  bus.rsp_data, exp_data);
        last_cycles = cycles;
        last_data   = bus.rsp_data;
        last_err    = bus.rsp_err;
        @(negedge clk);
        check({tag, ":rsp_pulse"},     bus.rsp_valid, 0);
        check({tag, ":req_ready_ret"}, bus.req_ready, 1);
        check({tag, ":beat_count"},    cap_addr.size(), eb_addr.size());
        n = (cap_addr.size() < eb_addr.size()) ? cap_addr.size() : eb_addr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, ":beat_addr"}, cap_addr[i], eb_addr[i]);
            check({tag, ":beat_be"},   cap_be[i],   eb_be[i]);
            check({tag, ":beat_we"},   cap_we[i],   we);
            if (we) check({tag, ":beat_wdata"}, cap_wd[i] & lane_mask(eb_be[i]), eb_wd[i]);
        end
        $display("[TB] %s we=%0d f3=%0d addr=%08h wdata=%08h -> err=%0d data=%08h beats=%0d cycles=%0d",
                 tag, we, f3, addr, wdata, last_err, last_data, cap_addr.size(), cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bit rwe;
        logic [2:0] rf3;
        logic [2:0] legal_ld [5];
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = '0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.mem_ready = 1'b1; bus2.mem_rvalid = 1'b0; bus2.mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'($urandom);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset:req_ready", bus.req_ready, 1);
        check("reset:mem_valid", bus.mem_valid, 0);
        check("reset:mem_be",    bus.mem_be, 0);
        check("reset:rsp_valid", bus.rsp_valid, 0);
        check("reset:rsp_err",   bus.rsp_err, 0);
        check("reset:rsp_data",  bus.rsp_data, 0);

        poke_word(32'h100, 32'hDEADBEEF);
        fast_bus = 1'b1;
        do_req(1'b0, 3'b010, 32'h100, 32'h0, "lw_aligned");
        check("lw_aligned:latency", last_cycles, 2);
        check("lw_aligned:data",    last_data, 32'hDEADBEEF);
        check("lw_aligned:be",      cap_be.size() > 0 ? cap_be[0] : 4'h0, 4'hF);
        fast_bus = 1'b0;

        poke_word(32'h100, 32'h80112233);
        do_req(1'b0, 3'b000, 32'h103, 32'h0, "lb_neg");
        check("lb_neg:data", last_data, 32'hFFFFFF80);
        check("lb_neg:be",   cap_be.size() > 0 ? cap_be[0] : 4'h0, 4'b1000);
        do_req(1'b0, 3'b100, 32'h103, 32'h0, "lbu");
        check("lbu:data", last_data, 32'h00000080);

        do_req(1'b1, 3'b001, 32'h102, 32'h0000ABCD, "sh_upper");
        check("sh_upper:be",    cap_be.size() > 0 ? cap_be[0] : 4'h0, 4'b1100);
        check("sh_upper:wdata", cap_wd.size() > 0 ? cap_wd[0][31:16] : 16'h0, 16'hABCD);
        check("sh_upper:err",   last_err, 0);

        poke_word(32'h0FC, 32'h55667788);
        poke_word(32'h100, 32'h99881122);
        do_req(1'b0, 3'b010, 32'h0FE, 32'h0, "lw_split");
        check("lw_split:data", last_data, 32'h11225566);
        check("lw_split:beats", cap_addr.size(), 2);
        if (cap_addr.size() == 2) begin
            check("lw_split:addr0", cap_addr[0], 32'h0FC);
            check("lw_split:be0",   cap_be[0],   4'b1100);
            check("lw_split:addr1", cap_addr[1], 32'h100);
            check("lw_split:be1",   cap_be[1],   4'b0011);
        end

        do_req(1'b0, 3'b011, 32'h100, 32'h0, "ld_rv32");
        check("ld_rv32:err",     last_err, 1);
        check("ld_rv32:latency", last_cycles, 1);
        do_req(1'b1, 3'b100, 32'h104, 32'h12345678, "st_f3_100");

        for (int t = 0; t < 150; t++) begin
            rwe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8)
                rf3 = rwe ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
            else
                rf3 = 3'($urandom_range(0, 7));
            do_req(rwe, rf3, 32'($urandom_range(0, 32'h3F0)), $urandom, "rand");
        end

        // Abort a stalled beat with reset
        hold_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h200;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("stall:mem_valid_held", bus.mem_valid, 1);
        check("stall:mem_addr_held",  bus.mem_addr, 32'h200);
        #2 rst = 1'b1;
        #1;
        check("abort:mem_valid_async", bus.mem_valid, 0);
        check("abort:rsp_valid",       bus.rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold_ready = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.mem_valid !== 1'b0) seen++;
        end
        check("abort:no_activity", seen, 0);
        check("abort:req_ready",   bus.req_ready, 1);
        $display("[TB] abort LW 0x200 under reset -> activity=%0d req_ready=%0d", seen, bus.req_ready);

        // Splitting disabled: crossing access is rejected without a bus beat
        dut2_mem_seen = 1'b0;
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_funct3 = 3'b010; bus2.req_addr = 32'h0FE;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        check("nosplit:rsp_valid", bus2.rsp_valid, 1);
        check("nosplit:rsp_err",   bus2.rsp_err, 1);
        check("nosplit:rsp_data",  bus2.rsp_data, 0);
        @(negedge clk);
        check("nosplit:rsp_pulse", bus2.rsp_valid, 0);
        check("nosplit:no_beat",   dut2_mem_seen, 0);
        $display("[TB] nosplit LW 0x0FE -> err=1 expected, beat_seen=%0d", dut2_mem_seen);
        bus2.req_valid = 1'b1; bus2.req_addr = 32'h100;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        check("nosplit_aligned:mem_valid", bus2.mem_valid, 1);
        check("nosplit_aligned:mem_be",    bus2.mem_be, 4'hF);
        $display("[TB] nosplit LW 0x100 -> mem_valid=%0d be=%0h", bus2.mem_valid, bus2.mem_be);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
